gencon_n: RTL and testbench

- Parametrised successor to the 16-bit signed calculator controller.
- Accepts decimal keypad digits, a sign toggle and an operator (add/sub/mul), computes in sign-magnitude, and drives a display word.
- New over the previous generation: configurable width and digit limit, a sequential shift-add multiplier, overflow saturation with flag, result chaining, and a clear input.
- Sits between the keypad/button debouncers and the display driver.

---
 rtl/gencon_n_if.sv | 25 ++
 rtl/gencon_n.sv | 256 +++++++++++++++++++++++++
 tb/tb_gencon_n.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gencon_n_if.sv
// Keypad/button inputs and display-side outputs of the gencon_n calculator controller.
interface gencon_n_if #(
   parameter int W = 16
);
   logic [3:0]   keypad_input;
   logic         read_input;
   logic [2:0]   operator_input;
   logic         equal_input;
   logic         clear_input;
   logic         complete;
   logic         overflow;
   logic         entry_err;
   logic [W-1:0] display_output;
   logic [2:0]   tb_current_state;

   modport master (
      output keypad_input, read_input, operator_input, equal_input, clear_input,
      input  complete, overflow, entry_err, display_output, tb_current_state
   );

   modport slave (
      input  keypad_input, read_input, operator_input, equal_input, clear_input,
      output complete, overflow, entry_err, display_output, tb_current_state
   );
endinterface

// File: rtl/gencon_n.sv
// Parametrised sign-magnitude keypad calculator: edge-detected entry, add/sub in one
// cycle, serial shift-add multiply, saturating result with overflow flag and chaining.
module gencon_n #(
   parameter int W          = 16,
   parameter int MAX_DIGITS = 5
) (
   input logic       clk,
   input logic       nRST,
   gencon_n_if.slave bus
);
   localparam int MW  = W - 1;
   localparam int PW  = 2 * MW;
   localparam int FW  = PW + 1;
   localparam int NW  = MW + 4;
   localparam int CW  = $clog2(MAX_DIGITS + 1);
   localparam int STW = $clog2(MW) + 1;
   localparam logic [MW-1:0] MAX_MAG = '1;
   localparam logic [2:0] OP_NEG = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   typedef enum logic [2:0] {
      ENTRY_A = 3'd0,
      COMPUTE = 3'd2,
      ENTRY_B = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t         state_reg, state_next;
   logic           read_prev_reg, equal_prev_reg, clear_prev_reg, op_prev_reg;
   logic           sign_a_reg, sign_a_next, sign_b_reg, sign_b_next;
   logic [MW-1:0]  mag_a_reg, mag_a_next, mag_b_reg, mag_b_next;
   logic [CW-1:0]  cnt_a_reg, cnt_a_next, cnt_b_reg, cnt_b_next;
   logic [2:0]     op_reg, op_next;
   logic           res_sign_reg, res_sign_next;
   logic [MW-1:0]  res_mag_reg, res_mag_next;
   logic           ovf_reg, ovf_next, err_reg, err_next;
   logic [PW-1:0]  acc_reg, acc_next, mcand_reg, mcand_next;
   logic [MW-1:0]  mplier_reg, mplier_next;
   logic [STW-1:0] step_reg, step_next;

   logic read_ev, equal_ev, clear_ev, op_ev, op_nz, op_arith;
   assign op_nz    = |bus.operator_input;
   assign read_ev  = bus.read_input  & ~read_prev_reg;
   assign equal_ev = bus.equal_input & ~equal_prev_reg;
   assign clear_ev = bus.clear_input & ~clear_prev_reg;
   assign op_ev    = op_nz & ~op_prev_reg;
   assign op_arith = (bus.operator_input == OP_ADD) || (bus.operator_input == OP_SUB) ||
                     (bus.operator_input == OP_MUL);

   // Candidate magnitude for the operand currently being typed.
   logic [MW-1:0] cur_mag;
   logic [CW-1:0] cur_cnt;
   logic [NW-1:0] cand;
   logic          digit_ok;
   always_comb begin
      cur_mag  = (state_reg == ENTRY_B) ? mag_b_reg : mag_a_reg;
      cur_cnt  = (state_reg == ENTRY_B) ? cnt_b_reg : cnt_a_reg;
      cand     = NW'(cur_mag) * NW'(10) + NW'(bus.keypad_input);
      digit_ok = (bus.keypad_input <= 4'd9) && (cur_cnt < CW'(MAX_DIGITS)) &&
                 (cand <= NW'(MAX_MAG));
   end

   logic signed [W:0] val_a, val_b, sum;
   logic [W:0]        sum_mag;
   always_comb begin
      val_a = $signed({2'b00, mag_a_reg});
      if (sign_a_reg) val_a = -val_a;
      val_b = $signed({2'b00, mag_b_reg});
      if (sign_b_reg ^ (op_reg == OP_SUB)) val_b = -val_b;
      sum     = val_a + val_b;
      sum_mag = sum[W] ? $unsigned(-sum) : $unsigned(sum);
   end

   logic [PW-1:0] acc_step;
   logic          mul_last;
   assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
   assign mul_last = (step_reg == STW'(MW - 1));

   // Saturate and normalise whichever result the current op produces.
   logic [FW-1:0] fin_mag;
   logic          fin_sign, fin_ovf;
   logic [MW-1:0] fin_res;
   always_comb begin
      if (op_reg == OP_MUL) begin
         fin_mag  = {1'b0, acc_step};
         fin_sign = sign_a_reg ^ sign_b_reg;
      end else begin
         fin_mag  = FW'(sum_mag);
         fin_sign = sum[W];
      end
      fin_ovf = fin_mag > FW'(MAX_MAG);
      fin_res = fin_ovf ? MAX_MAG : fin_mag[MW-1:0];
   end

   always_comb begin
      state_next    = state_reg;
      sign_a_next   = sign_a_reg;
      mag_a_next    = mag_a_reg;
      cnt_a_next    = cnt_a_reg;
      sign_b_next   = sign_b_reg;
      mag_b_next    = mag_b_reg;
      cnt_b_next    = cnt_b_reg;
      op_next       = op_reg;
      res_sign_next = res_sign_reg;
      res_mag_next  = res_mag_reg;
      ovf_next      = ovf_reg;
      err_next      = 1'b0;
      acc_next      = acc_reg;
      mcand_next    = mcand_reg;
      mplier_next   = mplier_reg;
      step_next     = step_reg;

      if (state_reg == COMPUTE) begin
         if (op_reg == OP_MUL) begin
            acc_next    = acc_step;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
            step_next   = step_reg + STW'(1);
         end
         if (op_reg != OP_MUL || mul_last) begin
            res_mag_next  = fin_res;
            res_sign_next = fin_sign & (fin_res != '0);
            ovf_next      = fin_ovf;
            state_next    = DONE;
         end
      end

      // Only the highest-priority event of a cycle is acted on.
      if (clear_ev) begin
         state_next    = ENTRY_A;
         sign_a_next   = 1'b0;
         mag_a_next    = '0;
         cnt_a_next    = '0;
         sign_b_next   = 1'b0;
         mag_b_next    = '0;
         cnt_b_next    = '0;
         op_next       = '0;
         res_sign_next = 1'b0;
         res_mag_next  = '0;
         ovf_next      = 1'b0;
      end else if (equal_ev) begin
         if (state_reg == ENTRY_B) begin
            state_next  = COMPUTE;
            acc_next    = '0;
            mcand_next  = PW'(mag_a_reg);
            mplier_next = mag_b_reg;
            step_next   = '0;
         end
      end else if (op_ev) begin
         if (bus.operator_input == OP_NEG) begin
            if (state_reg == ENTRY_A) sign_a_next = ~sign_a_reg;
            if (state_reg == ENTRY_B) sign_b_next = ~sign_b_reg;
         end else if (op_arith && (state_reg == ENTRY_A || state_reg == DONE)) begin
            if (state_reg == DONE) begin
               sign_a_next = res_sign_reg;
               mag_a_next  = res_mag_reg;
               ovf_next    = 1'b0;
            end
            op_next     = bus.operator_input;
            sign_b_next = 1'b0;
            mag_b_next  = '0;
            cnt_b_next  = '0;
            state_next  = ENTRY_B;
         end
      end else if (read_ev) begin
         if (state_reg == ENTRY_A || state_reg == ENTRY_B) begin
            if (digit_ok) begin
               if (state_reg == ENTRY_A) begin
                  mag_a_next = cand[MW-1:0];
                  cnt_a_next = cnt_a_reg + CW'(1);
               end else begin
                  mag_b_next = cand[MW-1:0];
                  cnt_b_next = cnt_b_reg + CW'(1);
               end
            end else begin
               err_next = 1'b1;
            end
         end else if (state_reg == DONE) begin
            if (bus.keypad_input <= 4'd9) begin
               sign_a_next = 1'b0;
               mag_a_next  = MW'(bus.keypad_input);
               cnt_a_next  = CW'(1);
               sign_b_next = 1'b0;
               mag_b_next  = '0;
               cnt_b_next  = '0;
               ovf_next    = 1'b0;
               state_next  = ENTRY_A;
            end else begin
               err_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_reg      <= ENTRY_A;
         read_prev_reg  <= 1'b0;
         equal_prev_reg <= 1'b0;
         clear_prev_reg <= 1'b0;
         op_prev_reg    <= 1'b0;
         sign_a_reg     <= 1'b0;
         mag_a_reg      <= '0;
         cnt_a_reg      <= '0;
         sign_b_reg     <= 1'b0;
         mag_b_reg      <= '0;
         cnt_b_reg      <= '0;
         op_reg         <= '0;
         res_sign_reg   <= 1'b0;
         res_mag_reg    <= '0;
         ovf_reg        <= 1'b0;
         err_reg        <= 1'b0;
         acc_reg        <= '0;
         mcand_reg      <= '0;
         mplier_reg     <= '0;
         step_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         read_prev_reg  <= bus.read_input;
         equal_prev_reg <= bus.equal_input;
         clear_prev_reg <= bus.clear_input;
         op_prev_reg    <= op_nz;
         sign_a_reg     <= sign_a_next;
         mag_a_reg      <= mag_a_next;
         cnt_a_reg      <= cnt_a_next;
         sign_b_reg     <= sign_b_next;
         mag_b_reg      <= mag_b_next;
         cnt_b_reg      <= cnt_b_next;
         op_reg         <= op_next;
         res_sign_reg   <= res_sign_next;
         res_mag_reg    <= res_mag_next;
         ovf_reg        <= ovf_next;
         err_reg        <= err_next;
         acc_reg        <= acc_next;
         mcand_reg      <= mcand_next;
         mplier_reg     <= mplier_next;
         step_reg       <= step_next;
      end
   end

   // COMPUTE keeps showing operand B, which stays untouched while the multiplier runs.
   always_comb begin
      case (state_reg)
         ENTRY_A: bus.display_output = {sign_a_reg, mag_a_reg};
         DONE:    bus.display_output = {res_sign_reg, res_mag_reg};
         default: bus.display_output = {sign_b_reg, mag_b_reg};
      endcase
   end

   assign bus.complete         = (state_reg == DONE);
   assign bus.overflow         = ovf_reg;
   assign bus.entry_err        = err_reg;
   assign bus.tb_current_state = state_reg;
endmodule

// File: tb/tb_gencon_n.sv
// Directed bench for gencon_n: a W=16 instance for the main scenarios, a W=8 instance for
// small-width saturation, clear in DONE and reset during a multiply.
module tb_gencon_n;
   logic clk = 1'b0;
   logic nrst16 = 1'b0;
   logic nrst8 = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   lat;

   always #5 clk = ~clk;

   gencon_n_if #(.W(16)) bus16 ();
   gencon_n_if #(.W(8))  bus8 ();

   gencon_n #(.W(16), .MAX_DIGITS(5)) u16 (.clk(clk), .nRST(nrst16), .bus(bus16));
   gencon_n #(.W(8),  .MAX_DIGITS(3)) u8  (.clk(clk), .nRST(nrst8),  .bus(bus8));

   task automatic key16(input logic [3:0] d);
      @(negedge clk); bus16.keypad_input = d; bus16.read_input = 1'b1;
      @(negedge clk); bus16.read_input = 1'b0;
   endtask

   task automatic op16(input logic [2:0] code);
      @(negedge clk); bus16.operator_input = code;
      @(negedge clk); bus16.operator_input = 3'd0;
   endtask

   task automatic clr16();
      @(negedge clk); bus16.clear_input = 1'b1;
      @(negedge clk); bus16.clear_input = 1'b0;
   endtask

   // lat counts cycles from the equal-accept cycle to the first cycle with complete high.
   task automatic eq16(input logic with_digit, input logic [3:0] d, output int cyc);
      @(negedge clk);
      bus16.equal_input = 1'b1;
      if (with_digit) begin bus16.keypad_input = d; bus16.read_input = 1'b1; end
      @(posedge clk); #1;
      bus16.equal_input = 1'b0; bus16.read_input = 1'b0;
      cyc = 1;
      while (!bus16.complete && cyc < 40) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic key8(input logic [3:0] d);
      @(negedge clk); bus8.keypad_input = d; bus8.read_input = 1'b1;
      @(negedge clk); bus8.read_input = 1'b0;
   endtask

   task automatic op8(input logic [2:0] code);
      @(negedge clk); bus8.operator_input = code;
      @(negedge clk); bus8.operator_input = 3'd0;
   endtask

   task automatic test_reset();
      checks++; if (bus16.tb_current_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus16.tb_current_state); end
      checks++; if (bus16.display_output !== 16'h0000) begin errors++; $display("FAIL reset_display got %h exp 0000", bus16.display_output); end
      checks++; if ({bus16.complete, bus16.overflow, bus16.entry_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {bus16.complete, bus16.overflow, bus16.entry_err}); end
   endtask

   task automatic test_add_neg();
      op16(3'd1); key16(4'd2); key16(4'd5);
      checks++; if (bus16.display_output !== 16'h8019) begin errors++; $display("FAIL add_entry_a got %h exp 8019", bus16.display_output); end
      op16(3'd2);
      checks++; if (bus16.tb_current_state !== 3'd3) begin errors++; $display("FAIL add_state_b got %0d exp 3", bus16.tb_current_state); end
      op16(3'd1); key16(4'd1); key16(4'd5);
      checks++; if (bus16.display_output !== 16'h800F) begin errors++; $display("FAIL add_entry_b got %h exp 800f", bus16.display_output); end
      eq16(1'b0, 4'd0, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
      checks++; if (bus16.display_output !== 16'h8028) begin errors++; $display("FAIL add_result got %h exp 8028", bus16.display_output); end
      checks++; if (bus16.overflow !== 1'b0) begin errors++; $display("FAIL add_overflow got %b exp 0", bus16.overflow); end
   endtask

   task automatic test_sub();
      clr16(); op16(3'd1); key16(4'd3); op16(3'd3); op16(3'd1); key16(4'd5);
      eq16(1'b0, 4'd0, lat);
      checks++; if (bus16.display_output !== 16'h0002) begin errors++; $display("FAIL sub_neg got %h exp 0002", bus16.display_output); end
      clr16(); key16(4'd5); op16(3'd3); key16(4'd5);
      eq16(1'b0, 4'd0, lat);
      checks++; if (bus16.display_output !== 16'h0000) begin errors++; $display("FAIL sub_zero got %h exp 0000", bus16.display_output); end
   endtask

   task automatic test_mul();
      clr16(); key16(4'd1); key16(4'd2); key16(4'd8); op16(3'd4); key16(4'd2); key16(4'd5); key16(4'd6);
      eq16(1'b0, 4'd0, lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL mul_latency got %0d exp 16", lat); end
      checks++; if (bus16.display_output !== 16'h7FFF) begin errors++; $display("FAIL mul_sat got %h exp 7fff", bus16.display_output); end
      checks++; if (bus16.overflow !== 1'b1) begin errors++; $display("FAIL mul_overflow got %b exp 1", bus16.overflow); end
      clr16();
      checks++; if ({bus16.tb_current_state, bus16.complete, bus16.overflow} !== 5'b000_0_0) begin errors++; $display("FAIL clear_done got state %0d cmp %b ovf %b exp 0 0 0", bus16.tb_current_state, bus16.complete, bus16.overflow); end
      op16(3'd1); key16(4'd3); op16(3'd4); key16(4'd5);
      eq16(1'b0, 4'd0, lat);
      checks++; if (bus16.display_output !== 16'h800F) begin errors++; $display("FAIL mul_negative got %h exp 800f", bus16.display_output); end
      clr16(); op16(3'd1); key16(4'd3); op16(3'd4); key16(4'd0);
      eq16(1'b0, 4'd0, lat);
      checks++; if (bus16.display_output !== 16'h0000) begin errors++; $display("FAIL mul_neg_zero got %h exp 0000", bus16.display_output); end
   endtask

   task automatic test_chain();
      clr16(); key16(4'd4); op16(3'd4); key16(4'd3);
      eq16(1'b0, 4'd0, lat);
      checks++; if (bus16.display_output !== 16'h000C) begin errors++; $display("FAIL chain_mul got %h exp 000c", bus16.display_output); end
      op16(3'd2);
      checks++; if (bus16.tb_current_state !== 3'd3 || bus16.display_output !== 16'h0000) begin errors++; $display("FAIL chain_to_b got state %0d disp %h exp 3 0000", bus16.tb_current_state, bus16.display_output); end
      key16(4'd5);
      eq16(1'b1, 4'd9, lat);
      checks++; if (bus16.display_output !== 16'h0011 || lat !== 2) begin errors++; $display("FAIL chain_add got %h lat %0d exp 0011 lat 2", bus16.display_output, lat); end
      key16(4'd7);
      checks++; if (bus16.tb_current_state !== 3'd0 || bus16.display_output !== 16'h0007 || bus16.complete !== 1'b0) begin errors++; $display("FAIL done_digit got state %0d disp %h cmp %b exp 0 0007 0", bus16.tb_current_state, bus16.display_output, bus16.complete); end
   endtask

   task automatic test_digits();
      clr16(); key16(4'd10);
      checks++; if (bus16.entry_err !== 1'b1 || bus16.display_output !== 16'h0000) begin errors++; $display("FAIL digit_gt9 got err %b disp %h exp 1 0000", bus16.entry_err, bus16.display_output); end
      key16(4'd3); key16(4'd2); key16(4'd7); key16(4'd6);
      checks++; if (bus16.display_output !== 16'h0CCC || bus16.entry_err !== 1'b0) begin errors++; $display("FAIL digit_3276 got %h err %b exp 0ccc 0", bus16.display_output, bus16.entry_err); end
      key16(4'd8);
      checks++; if (bus16.entry_err !== 1'b1) begin errors++; $display("FAIL digit_reject_err got %b exp 1", bus16.entry_err); end
      @(posedge clk); #1;
      checks++; if (bus16.entry_err !== 1'b0) begin errors++; $display("FAIL digit_err_pulse got %b exp 0", bus16.entry_err); end
      checks++; if (bus16.display_output !== 16'h0CCC) begin errors++; $display("FAIL digit_reject_hold got %h exp 0ccc", bus16.display_output); end
      key16(4'd9);
      checks++; if (bus16.entry_err !== 1'b1 || bus16.display_output !== 16'h0CCC) begin errors++; $display("FAIL digit_second_reject got err %b disp %h exp 1 0ccc", bus16.entry_err, bus16.display_output); end
      key16(4'd0);
      checks++; if (bus16.display_output !== 16'h7FF8 || bus16.entry_err !== 1'b0) begin errors++; $display("FAIL digit_fifth got %h err %b exp 7ff8 0", bus16.display_output, bus16.entry_err); end
      key16(4'd0);
      checks++; if (bus16.entry_err !== 1'b1 || bus16.display_output !== 16'h7FF8) begin errors++; $display("FAIL digit_sixth got err %b disp %h exp 1 7ff8", bus16.entry_err, bus16.display_output); end
      clr16();
      @(negedge clk); bus16.keypad_input = 4'd4; bus16.read_input = 1'b1;
      repeat (3) @(negedge clk);
      bus16.read_input = 1'b0;
      checks++; if (bus16.display_output !== 16'h0004) begin errors++; $display("FAIL digit_hold got %h exp 0004", bus16.display_output); end
   endtask

   task automatic test_w8();
      key8(4'd1); key8(4'd0); key8(4'd0); op8(3'd2); key8(4'd1); key8(4'd0); key8(4'd0);
      @(negedge clk); bus8.equal_input = 1'b1;
      @(negedge clk); bus8.equal_input = 1'b0;
      @(negedge clk);
      checks++; if (bus8.display_output !== 8'h7F || bus8.overflow !== 1'b1 || bus8.complete !== 1'b1) begin errors++; $display("FAIL w8_add_sat got %h ovf %b cmp %b exp 7f 1 1", bus8.display_output, bus8.overflow, bus8.complete); end
      @(negedge clk); bus8.clear_input = 1'b1;
      @(negedge clk); bus8.clear_input = 1'b0;
      checks++; if ({bus8.tb_current_state, bus8.complete, bus8.overflow, bus8.display_output} !== 13'd0) begin errors++; $display("FAIL w8_clear got state %0d cmp %b ovf %b disp %h exp all 0", bus8.tb_current_state, bus8.complete, bus8.overflow, bus8.display_output); end
      key8(4'd9); op8(3'd4); key8(4'd9);
      @(negedge clk); bus8.equal_input = 1'b1;
      @(negedge clk); bus8.equal_input = 1'b0;
      checks++; if (bus8.tb_current_state !== 3'd2) begin errors++; $display("FAIL w8_in_compute got %0d exp 2", bus8.tb_current_state); end
      @(negedge clk); nrst8 = 1'b0; #1;
      checks++; if ({bus8.tb_current_state, bus8.complete, bus8.overflow, bus8.entry_err, bus8.display_output} !== 14'd0) begin errors++; $display("FAIL w8_reset_mid_mul got state %0d cmp %b ovf %b err %b disp %h exp all 0", bus8.tb_current_state, bus8.complete, bus8.overflow, bus8.entry_err, bus8.display_output); end
      @(negedge clk); nrst8 = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (bus8.tb_current_state !== 3'd0 || bus8.complete !== 1'b0) begin errors++; $display("FAIL w8_after_reset got state %0d cmp %b exp 0 0", bus8.tb_current_state, bus8.complete); end
   endtask

   initial begin
      bus16.keypad_input = 4'd0; bus16.read_input = 1'b0; bus16.operator_input = 3'd0;
      bus16.equal_input = 1'b0; bus16.clear_input = 1'b0;
      bus8.keypad_input = 4'd0; bus8.read_input = 1'b0; bus8.operator_input = 3'd0;
      bus8.equal_input = 1'b0; bus8.clear_input = 1'b0;
      repeat (3) @(negedge clk);
      nrst16 = 1'b1; nrst8 = 1'b1;
      @(negedge clk);
      test_reset();
      test_add_neg();
      test_sub();
      test_mul();
      test_chain();
      test_digits();
      test_w8();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
